// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the fetch stage and the decoder that consumes its output.
package instr_fetch_queue_pkg;

  // Word address of an instruction (byte address bits [31:2]).
  typedef logic [29:0] word_addr_t;

  // Fetch request state: nothing pending, live request, or request whose data is stale.
  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DROP
  } fetch_state_e;

  localparam word_addr_t DEFAULT_RESET_PC = 30'h0;

  // One buffered entry is {pc, instruction word}.
  localparam int FETCH_ENTRY_W = 62;

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs; flush beats push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 62
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign count     = count_q;
  // An empty FIFO shows zeros so stale storage never leaks onto the outputs.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointers, count and storage contents; a write into a full FIFO is allowed only alongside a pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written because empty masks the head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues one word read at a time, buffers returned words with their PCs,
// and restarts at a redirect target while discarding any read already in flight.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter word_addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [29:0] mem_addr_I,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata_I,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [29:0] inst_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  word_addr_t         fetch_pc_q, fetch_pc_d;
  word_addr_t         mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;

  logic               fifo_push, fifo_pop, fifo_flush;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count, count_after;
  logic               room_after;
  logic [FETCH_ENTRY_W-1:0] fifo_head;

  assign fifo_flush = redirect_valid;
  assign fifo_pop   = inst_valid && inst_ready;
  assign fifo_push  = (state_q == FETCH_REQ) && mem_ack && !redirect_valid && (!fifo_full || fifo_pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({fetch_pc_q, mem_rdata_I}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = fifo_head[FETCH_ENTRY_W-1:32];
  assign inst_data  = fifo_head[31:0];
  assign mem_req    = mem_req_q;
  assign mem_addr_I = mem_addr_q;

  // Occupancy after this cycle's flush/push/pop decides whether another request may go out.
  always_comb begin
    count_after = fifo_count;
    if (fifo_flush) begin
      count_after = '0;
    end else if (fifo_push && !fifo_pop) begin
      count_after = fifo_count + CNT_W'(1);
    end else if (!fifo_push && fifo_pop) begin
      count_after = fifo_count - CNT_W'(1);
    end
    room_after = (count_after < CNT_W'(DEPTH));
  end

  // Fetch FSM next state; a redirect overrides everything, and an unacked read becomes DROP.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
      mem_req_d  = 1'b1;
      if (state_q == FETCH_IDLE || mem_ack) begin
        state_d    = FETCH_REQ;
        mem_addr_d = redirect_addr;
      end else begin
        state_d = FETCH_DROP;
      end
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (room_after) begin
            state_d    = FETCH_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end
        end
        FETCH_REQ: begin
          if (mem_ack) begin
            fetch_pc_d = fetch_pc_q + 30'd1;
            mem_addr_d = fetch_pc_q + 30'd1;
            if (room_after) begin
              mem_req_d = 1'b1;
            end else begin
              state_d   = FETCH_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end
        FETCH_DROP: begin
          if (mem_ack) begin
            state_d    = FETCH_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end
        end
        default: begin
          state_d   = FETCH_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // FSM, fetch PC and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios with a scoreboard of expected
// {pc, data} pairs popped by an independent monitor on every accepted instruction.
module tb_instr_fetch_queue;
   import instr_fetch_queue_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [29:0] mem_addr_I;
   logic        mem_ack;
   logic [31:0] mem_rdata_I;
   logic        redirect_valid;
   logic [29:0] redirect_addr;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [29:0] inst_pc;

   // Second instance that starts at the top of the address space to exercise PC wrap.
   logic        wMemReq;
   logic [29:0] wMemAddr;
   logic        wMemAck;
   logic [31:0] wMemRdata;
   logic        wInstValid;
   logic [31:0] wInstData;
   logic [29:0] wInstPc;
   logic        wRedirect = 1'b0;
   logic [29:0] wRedirectAddr = 30'h0;
   logic        wReady = 1'b1;

   typedef struct packed {
      logic [29:0] pc;
      logic [31:0] data;
   } expEntry_t;

   expEntry_t   expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          releaseCyc = 0;
   int          lastPopCyc = 0;
   bit          autoAck = 1'b1;
   int          ackDelay = 0;
   int          waitCnt = 0;
   logic [29:0] wPc [2];
   logic [31:0] wData [2];
   int          wIdx = 0;

   function automatic logic [31:0] dataFor(input logic [29:0] pc);
      return {2'b10, pc} ^ 32'h5A5A_5A5A;
   endfunction

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(30'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_addr_I     (mem_addr_I),
      .mem_ack        (mem_ack),
      .mem_rdata_I    (mem_rdata_I),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(30'h3FFFFFFF)) wrapDut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (wMemReq),
      .mem_addr_I     (wMemAddr),
      .mem_ack        (wMemAck),
      .mem_rdata_I    (wMemRdata),
      .redirect_valid (wRedirect),
      .redirect_addr  (wRedirectAddr),
      .inst_valid     (wInstValid),
      .inst_ready     (wReady),
      .inst_data      (wInstData),
      .inst_pc        (wInstPc)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter used to time pops relative to reset release.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   assign mem_rdata_I = dataFor(mem_addr_I);
   assign wMemAck     = wMemReq;
   assign wMemRdata   = dataFor(wMemAddr);

   // Memory model: acknowledges a request after ackDelay waiting cycles when in automatic mode.
   always begin
      @(posedge clk);
      #1;
      if (autoAck) begin
         if (mem_req) begin
            if (waitCnt >= ackDelay) begin
               mem_ack = 1'b1;
               waitCnt = 0;
            end else begin
               mem_ack = 1'b0;
               waitCnt = waitCnt + 1;
            end
         end else begin
            mem_ack = 1'b0;
            waitCnt = 0;
         end
      end
   end

   // Scoreboard monitor: every accepted instruction must match the next expected entry.
   // Handshakes during reset or redirect cycles are flushed downstream and are not checked.
   always @(negedge clk) begin
      expEntry_t e;
      if (inst_valid && inst_ready && !rst && !redirect_valid) begin
         checks = checks + 1;
         if (expQ.size() == 0) begin
            errors = errors + 1;
            $display("[TB] FAIL unexpectedPop: got pc=%h data=%h, expected no instruction", inst_pc, inst_data);
         end else begin
            e = expQ.pop_front();
            lastPopCyc = cyc;
            if (inst_pc !== e.pc || inst_data !== e.data) begin
               errors = errors + 1;
               $display("[TB] FAIL scoreboardPop: got pc=%h data=%h, expected pc=%h data=%h", inst_pc, inst_data, e.pc, e.data);
            end
         end
      end
   end

   // Captures the first two instructions from the wrap instance after each reset.
   always @(negedge clk) begin
      if (rst) begin
         wIdx = 0;
      end else if (wInstValid && wIdx < 2) begin
         wPc[wIdx]   = wInstPc;
         wData[wIdx] = wInstData;
         wIdx = wIdx + 1;
      end
   end

   // Watchdog so a stuck design still ends with a report.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic r, input logic rdy, input logic redir,
                                input logic [29:0] raddr, input logic ack);
      @(posedge clk);
      #1;
      rst            = r;
      inst_ready     = rdy;
      redirect_valid = redir;
      redirect_addr  = raddr;
      if (!autoAck) mem_ack = ack;
   endtask

   task automatic waitSample();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic resetDut(input logic rdy);
      applyStimulus(1'b1, 1'b0, 1'b0, 30'h0, 1'b0);
      applyStimulus(1'b0, rdy, 1'b0, 30'h0, 1'b0);
      releaseCyc = cyc;
   endtask

   task automatic pushExp(input logic [29:0] pc);
      expQ.push_back('{pc: pc, data: dataFor(pc)});
   endtask

   task automatic drainQueue(input int maxCycles);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n = n + 1;
      end while (expQ.size() != 0 && n < maxCycles);
      inst_ready = 1'b0;
      checks = checks + 1;
      if (expQ.size() != 0) begin
         errors = errors + 1;
         $display("[TB] FAIL drainTimeout: got %0d entries left, expected 0", expQ.size());
         expQ.delete();
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_memReq"},    {31'b0, mem_req},    32'h0);
      checkOutput({tag, "_memAddr"},   {2'b0, mem_addr_I},  32'h0);
      checkOutput({tag, "_instValid"}, {31'b0, inst_valid}, 32'h0);
      checkOutput({tag, "_instData"},  inst_data,           32'h0);
      checkOutput({tag, "_instPc"},    {2'b0, inst_pc},     32'h0);
   endtask

   initial begin
      rst            = 1'b1;
      mem_ack        = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 30'h0;

      // Streaming: ack and ready held high, one instruction per cycle.
      autoAck  = 1'b1;
      ackDelay = 0;
      resetDut(1'b1);
      waitSample();
      checkResetValues("reset");
      for (int i = 0; i < 8; i++) pushExp(30'(i));
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("stream_c1_memReq",    {31'b0, mem_req},    32'h1);
      checkOutput("stream_c1_memAddr",   {2'b0, mem_addr_I},  32'h0);
      checkOutput("stream_c1_instValid", {31'b0, inst_valid}, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("stream_c2_instValid", {31'b0, inst_valid}, 32'h1);
      checkOutput("stream_c2_memAddr",   {2'b0, mem_addr_I},  32'h1);
      drainQueue(30);
      checkOutput("stream_lastPopCycle", 32'(lastPopCyc - releaseCyc), 32'd9);
      checkOutput("wrap_firstPc",   {2'b0, wPc[0]}, 32'h3FFFFFFF);
      checkOutput("wrap_secondPc",  {2'b0, wPc[1]}, 32'h0);
      checkOutput("wrap_secondData", wData[1],      dataFor(30'h0));

      // Full FIFO: decoder stalled, exactly four words accepted, then resume at address 4.
      resetDut(1'b0);
      for (int i = 0; i < 6; i++) pushExp(30'(i));
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("full_c5_memReq", {31'b0, mem_req}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("full_c7_memReq",    {31'b0, mem_req},    32'h0);
      checkOutput("full_c7_instValid", {31'b0, inst_valid}, 32'h1);
      checkOutput("full_c7_headPc",    {2'b0, inst_pc},     32'h0);
      checkOutput("full_c7_headData",  inst_data,           dataFor(30'h0));
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("full_resume_memReq",  {31'b0, mem_req},   32'h1);
      checkOutput("full_resume_memAddr", {2'b0, mem_addr_I}, 32'h4);
      drainQueue(30);

      // Slow memory: ack arrives on the fourth cycle of the request; address must hold.
      ackDelay = 3;
      resetDut(1'b1);
      pushExp(30'h0);
      pushExp(30'h1);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
         waitSample();
         checkOutput($sformatf("slow_c%0d_memAddr", k),   {2'b0, mem_addr_I},  32'h0);
         checkOutput($sformatf("slow_c%0d_instValid", k), {31'b0, inst_valid}, 32'h0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("slow_c5_memAddr", {2'b0, mem_addr_I}, 32'h1);
      drainQueue(40);
      ackDelay = 0;

      // Redirect while the read of 0x5 is pending: 0x5 data is dropped, fetch restarts at 0x100.
      autoAck = 1'b0;
      mem_ack = 1'b0;
      resetDut(1'b1);
      pushExp(30'h0);
      pushExp(30'h1);
      pushExp(30'h100);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("drop_pendingAddr", {2'b0, mem_addr_I}, 32'h5);
      applyStimulus(1'b0, 1'b0, 1'b1, 30'h100, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1);
      waitSample();
      checkOutput("drop_flushValid", {31'b0, inst_valid}, 32'h0);
      checkOutput("drop_holdReq",    {31'b0, mem_req},    32'h1);
      checkOutput("drop_holdAddr",   {2'b0, mem_addr_I},  32'h5);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b1);
      waitSample();
      checkOutput("drop_newAddr",       {2'b0, mem_addr_I},  32'h100);
      checkOutput("drop_discardValid",  {31'b0, inst_valid}, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      drainQueue(20);

      // Redirect coinciding with ack and pop: returned word discarded, restart at 0x200.
      resetDut(1'b0);
      pushExp(30'h200);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 30'h200, 1'b1);
      waitSample();
      checkOutput("redirAck_preValid", {31'b0, inst_valid}, 32'h1);
      checkOutput("redirAck_preAddr",  {2'b0, mem_addr_I},  32'h2);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b1);
      waitSample();
      checkOutput("redirAck_flushValid", {31'b0, inst_valid}, 32'h0);
      checkOutput("redirAck_memReq",     {31'b0, mem_req},    32'h1);
      checkOutput("redirAck_memAddr",    {2'b0, mem_addr_I},  32'h200);
      applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      drainQueue(20);

      // Reset asserted mid-stream returns every output to its reset value.
      autoAck = 1'b1;
      resetDut(1'b1);
      pushExp(30'h0);
      pushExp(30'h1);
      pushExp(30'h2);
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 30'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkResetValues("midReset");
      checkOutput("midReset_expDrained", 32'(expQ.size()), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      waitSample();
      checkOutput("midReset_restartReq",  {31'b0, mem_req},   32'h1);
      checkOutput("midReset_restartAddr", {2'b0, mem_addr_I}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
